// File: rtl/button_debounce_if.sv
// Button conditioner bus: timebase and raw pin in, debounced level and event strobes out.
// The release strobe is btn_release because "release" is a reserved word.
interface button_debounce_if;
  logic tick;
  logic btn_in;
  logic btn_level;
  logic press;
  logic btn_release;
  logic long_press;

  modport master (output tick, btn_in, input btn_level, press, btn_release, long_press);
  modport slave  (input tick, btn_in, output btn_level, press, btn_release, long_press);
endinterface

// File: rtl/button_debounce.sv
// Tick-driven push-button debouncer: 2-flop sync, stable-tick filter, press/release/long-press strobes.
// All outputs are registered and update on the edge that samples the qualifying tick.
module button_debounce #(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 1000,
  parameter bit ACTIVE_LOW     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  button_debounce_if.slave bus
);
  localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int LW = (LONG_TICKS > 1) ? $clog2(LONG_TICKS) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [LW-1:0] LMAX = LW'(LONG_TICKS - 1);

  typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, RELEASE_PEND} state_t;

  state_t        state, state_n;
  logic [1:0]    sync;
  logic          act;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [LW-1:0] lcnt, lcnt_n;
  logic          long_fired, long_fired_n;
  logic          level, level_n;
  logic          press_q, press_n;
  logic          rel_q, rel_n;
  logic          long_q, long_n;

  // Sync flops idle at the released pin level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) sync <= {2{ACTIVE_LOW}};
    else     sync <= {sync[0], bus.btn_in};
  end

  assign act = sync[1] ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dcnt       <= '0;
      lcnt       <= '0;
      long_fired <= 1'b0;
      level      <= 1'b0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state      <= state_n;
      dcnt       <= dcnt_n;
      lcnt       <= lcnt_n;
      long_fired <= long_fired_n;
      level      <= level_n;
      press_q    <= press_n;
      rel_q      <= rel_n;
      long_q     <= long_n;
    end
  end

  // Input-change exits are tested before tick so a coinciding tick is never counted.
  always_comb begin
    state_n      = state;
    dcnt_n       = dcnt;
    lcnt_n       = lcnt;
    long_fired_n = long_fired;
    level_n      = level;
    press_n      = 1'b0;
    rel_n        = 1'b0;
    long_n       = 1'b0;
    case (state)
      IDLE: begin
        if (act) begin
          state_n = PRESS_PEND;
          dcnt_n  = '0;
        end
      end
      PRESS_PEND: begin
        if (!act) begin
          state_n = IDLE;
        end else if (bus.tick) begin
          if (dcnt == DMAX) begin
            state_n = HELD;
            level_n = 1'b1;
            press_n = 1'b1;
            dcnt_n  = '0;
            lcnt_n  = '0;
          end else begin
            dcnt_n = dcnt + DW'(1);
          end
        end
      end
      HELD: begin
        if (!act) begin
          state_n = RELEASE_PEND;
          dcnt_n  = '0;
        end else if (bus.tick && !long_fired) begin
          if (lcnt == LMAX) begin
            long_n       = 1'b1;
            long_fired_n = 1'b1;
          end else begin
            lcnt_n = lcnt + LW'(1);
          end
        end
      end
      RELEASE_PEND: begin
        // lcnt is frozen here so a release glitch only pauses the long-press timer.
        if (act) begin
          state_n = HELD;
          dcnt_n  = '0;
        end else if (bus.tick) begin
          if (dcnt == DMAX) begin
            state_n      = IDLE;
            level_n      = 1'b0;
            rel_n        = 1'b1;
            long_fired_n = 1'b0;
          end else begin
            dcnt_n = dcnt + DW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.btn_level   = level;
  assign bus.press       = press_q;
  assign bus.btn_release = rel_q;
  assign bus.long_press  = long_q;
endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench: stimulus queues expected strobes (kind, cycle); a negedge monitor pops and compares.
module tb_button_debounce;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   passes = 0;
  int   total = 0;

  typedef struct { int kind; int cyc; } exp_t;  // kind: 0 press, 1 release, 2 long
  exp_t q0[$];
  exp_t q1[$];

  button_debounce_if bi0();
  button_debounce_if bi1();

  button_debounce #(.DEBOUNCE_TICKS(4), .LONG_TICKS(10), .ACTIVE_LOW(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bus(bi0));
  button_debounce #(.DEBOUNCE_TICKS(4), .LONG_TICKS(10), .ACTIVE_LOW(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(bi1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut0 timebase: tick sampled on every posedge whose number is a multiple of 8.
  initial begin
    bi0.tick = 1'b0;
    forever begin
      @(posedge clk);
      #1 bi0.tick = ((cyc + 1) % 8 == 0);
    end
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, exp, cyc);
  endtask

  task automatic push(input int id, input int kind, input int c);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_aligned();
    do step(1); while (cyc % 8 != 0);
  endtask

  task automatic mon(input int id, input logic p, input logic r, input logic l, input logic lvl);
    exp_t e;
    int   k;
    if (!(p || r || l)) return;
    check($sformatf("strobe_onehot_dut%0d", id), int'(p) + int'(r) + int'(l), 1);
    k = p ? 0 : (r ? 1 : 2);
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      total++;
      $display("FAIL unexpected_strobe_dut%0d: got kind %0d at cyc %0d, expected none", id, k, cyc);
      return;
    end
    if (id == 0) e = q0.pop_front();
    else         e = q1.pop_front();
    check($sformatf("strobe_kind_dut%0d", id), k, e.kind);
    check($sformatf("strobe_cyc_dut%0d", id), cyc, e.cyc);
    check($sformatf("strobe_level_dut%0d", id), int'(lvl), (k == 1) ? 0 : 1);
  endtask

  always @(negedge clk) begin
    mon(0, bi0.press, bi0.btn_release, bi0.long_press, bi0.btn_level);
    mon(1, bi1.press, bi1.btn_release, bi1.long_press, bi1.btn_level);
  end

  task automatic check_zero(input string name, input int id);
    if (id == 0)
      check(name, {bi0.btn_level, bi0.press, bi0.btn_release, bi0.long_press}, 0);
    else
      check(name, {bi1.btn_level, bi1.press, bi1.btn_release, bi1.long_press}, 0);
  endtask

  initial begin
    int n0;
    int p;
    rst = 1'b1;
    bi0.btn_in = 1'b1;
    bi1.btn_in = 1'b0;
    bi1.tick   = 1'b1;
    step(3);
    check_zero("reset_outputs_dut0", 0);
    check_zero("reset_outputs_dut1", 1);
    rst = 1'b0;
    step(5);

    // 1: clean press, then release before the long-press timer expires
    wait_aligned();
    n0 = cyc;
    bi0.btn_in = 1'b0;
    push(0, 0, n0 + 32);
    step(24);
    check("s1_level_before_press", bi0.btn_level, 0);
    step(24);
    check("s1_level_held", bi0.btn_level, 1);
    bi0.btn_in = 1'b1;
    push(0, 1, n0 + 80);
    step(40);
    check("s1_level_after_release", bi0.btn_level, 0);

    // 2: bounce rejection, 2 ticks low then 2 ticks high, five times
    for (int i = 0; i < 5; i++) begin
      wait_aligned();
      bi0.btn_in = 1'b0;
      step(16);
      bi0.btn_in = 1'b1;
      step(15);
      check("s2_bounce_level", bi0.btn_level, 0);
    end

    // 3: long press then release
    wait_aligned();
    n0 = cyc;
    bi0.btn_in = 1'b0;
    push(0, 0, n0 + 32);
    push(0, 2, n0 + 112);
    step(240);
    check("s3_level_held", bi0.btn_level, 1);
    bi0.btn_in = 1'b1;
    push(0, 1, n0 + 272);
    step(48);
    check("s3_level_released", bi0.btn_level, 0);

    // 4: release glitch at lcnt=2 pauses the long-press timer by 2 ticks
    wait_aligned();
    n0 = cyc;
    p  = n0 + 32;
    bi0.btn_in = 1'b0;
    push(0, 0, p);
    step(48);
    bi0.btn_in = 1'b1;
    step(16);
    check("s4_level_in_glitch", bi0.btn_level, 1);
    bi0.btn_in = 1'b0;
    push(0, 2, p + 96);
    step(80);
    check("s4_level_held", bi0.btn_level, 1);
    bi0.btn_in = 1'b1;
    push(0, 1, p + 144);
    step(48);
    check("s4_level_released", bi0.btn_level, 0);

    // 5: reset in PRESS_PEND (dcnt=2) and again in HELD
    wait_aligned();
    n0 = cyc;
    bi0.btn_in = 1'b0;
    step(16);
    rst = 1'b1;
    step(1);
    check_zero("s5_reset_pend_outputs", 0);
    rst = 1'b0;
    push(0, 0, n0 + 48);
    step(39);
    check("s5_level_held", bi0.btn_level, 1);
    rst = 1'b1;
    step(1);
    check_zero("s5_reset_held_outputs", 0);
    rst = 1'b0;
    push(0, 0, n0 + 88);
    step(39);
    bi0.btn_in = 1'b1;
    push(0, 1, n0 + 128);
    step(48);
    check("s5_level_released", bi0.btn_level, 0);

    // 6: tick tied high, active-high pin
    step(1);
    n0 = cyc;
    bi1.btn_in = 1'b1;
    push(1, 0, n0 + 7);
    push(1, 2, n0 + 17);
    step(6);
    check("s6_level_before_press", bi1.btn_level, 0);
    step(24);
    check("s6_level_held", bi1.btn_level, 1);
    bi1.btn_in = 1'b0;
    push(1, 1, n0 + 37);
    step(20);
    check("s6_level_released", bi1.btn_level, 0);

    step(10);
    check("dut0_expected_left", q0.size(), 0);
    check("dut1_expected_left", q1.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/button_debounce.md
# button_debounce

Tick-driven push-button conditioner that sits directly downstream of the Hz clock divider. It consumes the divider's one-cycle `dividedPulse` strobe as a debounce timebase, typically 1 kHz. It synchronises a raw asynchronous button input, filters contact bounce, and produces a clean level plus one-cycle press, release and long-press strobes for the application logic. All logic runs in the single 16 MHz `clk` domain.

## Interface
- `DEBOUNCE_TICKS`, default 20: number of consecutive ticks the input must be stable to accept a change. Must be ≥ 1.
- `LONG_TICKS`, default 1000: number of ticks held, counted after an accepted press, before `long_press` fires. Must be ≥ 1.
- `ACTIVE_LOW`, default 1: 1 = button pulls the pin low when pressed; 0 = active high.
- `clk`  in  1  system clock, 16 MHz.
- `rst`  in  1  reset: synchronous, active-high.
- `tick`  in  1  one-`clk`-wide timebase strobe from the divider's pulse output.
- `btn_in`  in  1  raw asynchronous button pin.
- `btn_level`  out  1  debounced state: 1 = pressed.
- `press`  out  1  one-cycle strobe when a press is accepted.
- `release`  out  1  one-cycle strobe when a release is accepted.
- `long_press`  out  1  one-cycle strobe, at most once per press.

## Operation
- **Synchroniser:** two-flop synchroniser on `btn_in`. Both flops reset to the idle pin level (`ACTIVE_LOW`). `act` = second flop XOR `ACTIVE_LOW`.
- **Counters:** `dcnt` is sized $clog2(DEBOUNCE_TICKS) and is at least 1 bit. `lcnt` is sized $clog2(LONG_TICKS) and is at least 1 bit. Neither counter ever exceeds N-1, so no wrap is possible.
- **Flag:** `long_fired` records that `long_press` has already fired for the current press.
- **FSM states:** IDLE, PRESS_PEND, HELD, RELEASE_PEND. Reset state is IDLE.
- **IDLE:**
  - `act`=1 → PRESS_PEND, `dcnt`←0.
- **PRESS_PEND:**
  - `act`=0 → IDLE. This is checked every `clk` and takes priority over `tick`.
  - `tick` with `dcnt`=`DEBOUNCE_TICKS`-1 → HELD. `btn_level`←1, `press`←1, `dcnt`←0, `lcnt`←0.
  - `tick` otherwise → `dcnt`++.
- **HELD:**
  - `act`=0 → RELEASE_PEND, `dcnt`←0.
  - `tick` with `long_fired`=0 and `lcnt`=`LONG_TICKS`-1 → `long_press`←1, `long_fired`←1.
  - `tick` with `long_fired`=0 otherwise → `lcnt`++.
- **RELEASE_PEND:**
  - `act`=1 → HELD (bounce). `dcnt`←0. `lcnt` keeps its value and resumes counting from it.
  - `tick` with `dcnt`=`DEBOUNCE_TICKS`-1 → IDLE. `btn_level`←0, `release`←1, `long_fired`←0.
  - `tick` otherwise → `dcnt`++.
  - `lcnt` does not advance in this state.
- **Strobes:** `press`, `release` and `long_press` default to 0 every cycle and are never high for 2 consecutive cycles.
- **`tick` tied high:** legal. The block then counts on every `clk`, which benches use for fast simulation.

## Timing
- **Reset values:** `btn_level`, `press`, `release` and `long_press` are all 0. FSM is IDLE, counters are 0, `long_fired` is 0.
- **Reset mid-operation:** reset takes effect on the next edge. No strobe is emitted during or because of reset.
- **Registered outputs:** all outputs are registered. They update on the same edge that samples the qualifying `tick`, so each strobe is valid for exactly the following cycle.
- **Press latency:** 2 synchroniser cycles, then `DEBOUNCE_TICKS` ticks observed with `act`=1. In wall time this is (N-1, N] tick periods after synchronisation.
- **Long-press latency:** `long_press` fires `LONG_TICKS` HELD-state ticks after `press`. The tick that accepts the press is not counted.
- **`act` change coinciding with `tick`:** the state-exit branch wins and no count occurs.
- **`DEBOUNCE_TICKS`=1:** the first tick after the state entry accepts the change.

## Test plan
Common setup: `DEBOUNCE_TICKS`=4, `LONG_TICKS`=10, `ACTIVE_LOW`=1, `tick` every 8 `clk`.

1. **Clean press:** `btn_in` 1→0 and held → `press` high for 1 cycle after the 4th tick following synchronisation; `btn_level`=1 in the same cycle. No `release` or `long_press`.
2. **Bounce rejection:** `btn_in` low for 2 ticks then high, repeated 5 times → `btn_level` stays 0 and no strobes.
3. **Long press and release:** hold low for 30 ticks, then high → `long_press` exactly once, 10 ticks after `press`. `release` follows 4 ticks after the rising input, with `btn_level`→0.
4. **Release glitch:** in HELD, at lcnt=2 (two ticks after `press`), drive `btn_in` high for 2 ticks then low again → no `release` and `btn_level` stays 1. `long_press` fires 2 ticks later than in scenario 3, i.e. 12 ticks after `press`, because `lcnt` paused during RELEASE_PEND.
5. **Reset mid-operation:** assert `rst` once in PRESS_PEND (`dcnt`=2) and again in HELD → all outputs 0 next cycle and no strobes. A subsequent press again requires the full 4 ticks.
6. **Fast timebase:** `tick` tied to 1 and `ACTIVE_LOW`=0, `btn_in` 0→1 → `press` in the cycle after the 4th post-synchroniser clock edge; `long_press` 10 cycles after `press`.
